// File: rtl/uart_tx_sched_if.sv
// Requester and transmitter-side signals of the two-requester UART byte scheduler.
// The scheduler connects through the slave modport; the requesters and transmitter use master.
interface uart_tx_sched_if #(
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic          req0_valid;
    logic [7:0]    req0_data;
    logic          req0_ready;
    logic          req1_valid;
    logic [7:0]    req1_data;
    logic          req1_ready;
    logic [7:0]    tx_data;
    logic          tx_en;
    logic          tx_busy;
    logic [CW-1:0] cnt0;
    logic [CW-1:0] cnt1;
    logic          sched_busy;
    logic          tmo_err;
    logic          tmo_clr;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, tx_busy, tmo_clr,
        input  req0_ready, req1_ready, tx_data, tx_en, cnt0, cnt1, sched_busy, tmo_err
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, tx_busy, tmo_clr,
        output req0_ready, req1_ready, tx_data, tx_en, cnt0, cnt1, sched_busy, tmo_err
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Two-requester byte scheduler feeding a UART transmitter: per-requester FIFOs,
// round-robin grant, tx_en strobe and a watchdog on the transmitter's busy handshake.
module uart_tx_sched #(
    parameter int DEPTH    = 4,
    parameter int BUSY_TMO = 16
) (
    input  logic           clk,
    input  logic           rstn,
    uart_tx_sched_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(BUSY_TMO + 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_HI, WAIT_LO} state_t;

    logic [7:0]    fifo0_q [DEPTH];
    logic [7:0]    fifo1_q [DEPTH];
    logic [AW-1:0] wr0_q, rd0_q, wr1_q, rd1_q;
    logic [CW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    state_t        state_q;
    logic [7:0]    tx_data_q;
    logic          tx_en_q;
    logic          last_grant_q;
    logic [TW-1:0] tmo_cnt_q;
    logic          tmo_err_q;

    logic ready0, ready1, push0, push1, has0, has1, idle, pop0, pop1, tmo_set;

    assign ready0 = (cnt0_q != CW'(DEPTH));
    assign ready1 = (cnt1_q != CW'(DEPTH));
    assign push0  = bus.req0_valid & ready0;
    assign push1  = bus.req1_valid & ready1;
    assign has0   = (cnt0_q != '0);
    assign has1   = (cnt1_q != '0);
    assign idle   = (state_q == IDLE);

    // On a tie the FIFO that did not get the previous grant wins.
    assign pop0 = idle & has0 & (~has1 | last_grant_q);
    assign pop1 = idle & has1 & (~has0 | ~last_grant_q);

    assign tmo_set = (state_q == WAIT_HI) & ~bus.tx_busy & (tmo_cnt_q == TW'(BUSY_TMO - 1));

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (push0 & ~pop0)
            cnt0_d = cnt0_q + 1'b1;
        else if (~push0 & pop0)
            cnt0_d = cnt0_q - 1'b1;
        if (push1 & ~pop1)
            cnt1_d = cnt1_q + 1'b1;
        else if (~push1 & pop1)
            cnt1_d = cnt1_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push0)
            fifo0_q[wr0_q] <= bus.req0_data;
        if (push1)
            fifo1_q[wr1_q] <= bus.req1_data;
    end

    // Pointers are exactly AW bits wide, so wrap-around is the natural overflow.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr0_q  <= '0;
            rd0_q  <= '0;
            wr1_q  <= '0;
            rd1_q  <= '0;
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (push0)
                wr0_q <= wr0_q + 1'b1;
            if (pop0)
                rd0_q <= rd0_q + 1'b1;
            if (push1)
                wr1_q <= wr1_q + 1'b1;
            if (pop1)
                rd1_q <= rd1_q + 1'b1;
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            tx_data_q    <= '0;
            tx_en_q      <= 1'b0;
            last_grant_q <= 1'b1;
            tmo_cnt_q    <= '0;
            tmo_err_q    <= 1'b0;
        end else begin
            tx_en_q   <= 1'b0;
            tmo_err_q <= tmo_set | (tmo_err_q & ~bus.tmo_clr);
            case (state_q)
                IDLE: begin
                    if (pop0 | pop1) begin
                        tx_data_q    <= pop0 ? fifo0_q[rd0_q] : fifo1_q[rd1_q];
                        last_grant_q <= pop1;
                        tx_en_q      <= 1'b1;
                        state_q      <= LOAD;
                    end
                end
                LOAD: begin
                    tmo_cnt_q <= '0;
                    state_q   <= WAIT_HI;
                end
                WAIT_HI: begin
                    // A transmitter that never reports busy loses the byte.
                    if (bus.tx_busy)
                        state_q <= WAIT_LO;
                    else if (tmo_set)
                        state_q <= IDLE;
                    else
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                end
                WAIT_LO: begin
                    if (!bus.tx_busy)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.cnt0       = cnt0_q;
    assign bus.cnt1       = cnt1_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.tx_en      = tx_en_q;
    assign bus.sched_busy = ~idle;
    assign bus.tmo_err    = tmo_err_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched with a behavioural UART transmitter
// that logs every byte strobed by tx_en.
module tb_uart_tx_sched;
    localparam int DEPTH    = 4;
    localparam int BUSY_TMO = 16;

    logic clk = 1'b0;
    logic rstn;

    uart_tx_sched_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_sched #(.DEPTH(DEPTH), .BUSY_TMO(BUSY_TMO)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int testsRun    = 0;
    int testsFailed = 0;
    // 0: busy 2 cycles after tx_en for 10 cycles, 1: busy stuck high, 2: busy stuck low
    int xmitMode    = 0;
    logic [7:0] logTx[$];

    typedef struct {
        bit         sel;
        logic [7:0] data;
        logic [7:0] expTx;
        int         expCnt;
        int         expBusyCycles;
        int         expEnPulses;
    } vec_t;

    vec_t vecs [5];

    // Transmitter model: acts 1 ns after each rising edge, away from the sampling edge.
    initial begin
        bus.tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.tx_en)
                logTx.push_back(bus.tx_data);
            if (xmitMode == 1) begin
                bus.tx_busy = 1'b1;
            end else if (xmitMode == 2) begin
                bus.tx_busy = 1'b0;
            end else begin
                bus.tx_busy = 1'b0;
                if (bus.tx_en && rstn) begin
                    repeat (2) @(posedge clk);
                    #1 bus.tx_busy = 1'b1;
                    for (int i = 0; i < 10 && rstn; i++) begin
                        @(posedge clk);
                        #1;
                    end
                    bus.tx_busy = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Present one byte per requester for a single cycle; call and return at a falling edge.
    task automatic applyStimulus(input bit v0, input logic [7:0] d0, input bit v1, input logic [7:0] d1);
        bus.req0_valid = v0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_data  = d1;
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int cycles;
        cycles = 0;
        while (!(bus.sched_busy == 1'b0 && bus.cnt0 == '0 && bus.cnt1 == '0) && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        if (cycles >= budget) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL waitIdle: got still busy after %0d cycles, expected idle", budget);
        end
    endtask

    function automatic logic [31:0] logAt(input int idx);
        if (idx < logTx.size())
            return 32'(logTx[idx]);
        return 32'hxxxx_xxxx;
    endfunction

    initial begin
        int base;
        int n;
        int enCount;

        vecs[0] = '{sel: 1'b0, data: 8'h41, expTx: 8'h41, expCnt: 1, expBusyCycles: 13, expEnPulses: 1};
        vecs[1] = '{sel: 1'b1, data: 8'hA5, expTx: 8'hA5, expCnt: 1, expBusyCycles: 13, expEnPulses: 1};
        vecs[2] = '{sel: 1'b0, data: 8'h00, expTx: 8'h00, expCnt: 1, expBusyCycles: 13, expEnPulses: 1};
        vecs[3] = '{sel: 1'b1, data: 8'hFF, expTx: 8'hFF, expCnt: 1, expBusyCycles: 13, expEnPulses: 1};
        vecs[4] = '{sel: 1'b0, data: 8'h3C, expTx: 8'h3C, expCnt: 1, expBusyCycles: 13, expEnPulses: 1};

        bus.req0_valid = 1'b0;
        bus.req0_data  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_data  = '0;
        bus.tmo_clr    = 1'b0;
        rstn           = 1'b0;

        @(negedge clk);
        checkOutput("reset tx_en", 32'(bus.tx_en), 0);
        checkOutput("reset tx_data", 32'(bus.tx_data), 0);
        checkOutput("reset cnt0", 32'(bus.cnt0), 0);
        checkOutput("reset cnt1", 32'(bus.cnt1), 0);
        checkOutput("reset req0_ready", 32'(bus.req0_ready), 1);
        checkOutput("reset req1_ready", 32'(bus.req1_ready), 1);
        checkOutput("reset sched_busy", 32'(bus.sched_busy), 0);
        checkOutput("reset tmo_err", 32'(bus.tmo_err), 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        $display("[TB] contention after reset");
        base = logTx.size();
        applyStimulus(1'b1, 8'h10, 1'b1, 8'h20);
        applyStimulus(1'b1, 8'h11, 1'b1, 8'h21);
        waitIdle(200);
        checkOutput("contention count", 32'(logTx.size() - base), 4);
        checkOutput("contention byte0", logAt(base),     32'h10);
        checkOutput("contention byte1", logAt(base + 1), 32'h20);
        checkOutput("contention byte2", logAt(base + 2), 32'h11);
        checkOutput("contention byte3", logAt(base + 3), 32'h21);

        $display("[TB] single-byte vectors");
        for (int i = 0; i < 5; i++) begin
            base = logTx.size();
            applyStimulus(!vecs[i].sel, vecs[i].data, vecs[i].sel, vecs[i].data);
            checkOutput($sformatf("vec%0d cnt after push", i),
                        32'(vecs[i].sel ? bus.cnt1 : bus.cnt0), 32'(vecs[i].expCnt));
            @(negedge clk);
            checkOutput($sformatf("vec%0d tx_en", i), 32'(bus.tx_en), 1);
            checkOutput($sformatf("vec%0d tx_data", i), 32'(bus.tx_data), 32'(vecs[i].expTx));
            checkOutput($sformatf("vec%0d cnt after pop", i),
                        32'(vecs[i].sel ? bus.cnt1 : bus.cnt0), 0);
            n = 0;
            enCount = 0;
            while (bus.sched_busy && n < 100) begin
                n++;
                if (bus.tx_en)
                    enCount++;
                @(negedge clk);
            end
            checkOutput($sformatf("vec%0d busy cycles", i), 32'(n), 32'(vecs[i].expBusyCycles));
            checkOutput($sformatf("vec%0d tx_en pulses", i), 32'(enCount), 32'(vecs[i].expEnPulses));
            checkOutput($sformatf("vec%0d sent byte", i), logAt(base), 32'(vecs[i].expTx));
            checkOutput($sformatf("vec%0d tx_busy low at idle", i), 32'(bus.tx_busy), 0);
        end

        $display("[TB] full FIFO with busy stuck high");
        xmitMode = 1;
        repeat (2) @(negedge clk);
        base = logTx.size();
        applyStimulus(1'b0, 8'h00, 1'b1, 8'hA0);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'hA1);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'hA2);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'hA3);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'hA4);
        checkOutput("full cnt1", 32'(bus.cnt1), 4);
        checkOutput("full req1_ready", 32'(bus.req1_ready), 0);
        checkOutput("full in-flight count", 32'(logTx.size() - base), 1);
        checkOutput("full in-flight byte", 32'(bus.tx_data), 32'hA0);
        checkOutput("full req0_ready", 32'(bus.req0_ready), 1);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'hAF);
        checkOutput("full push ignored cnt1", 32'(bus.cnt1), 4);
        xmitMode = 0;
        waitIdle(200);
        checkOutput("full drain count", 32'(logTx.size() - base), 5);
        checkOutput("full drain byte1", logAt(base + 1), 32'hA1);
        checkOutput("full drain byte2", logAt(base + 2), 32'hA2);
        checkOutput("full drain byte3", logAt(base + 3), 32'hA3);
        checkOutput("full drain byte4", logAt(base + 4), 32'hA4);

        $display("[TB] busy timeout");
        xmitMode = 2;
        repeat (2) @(negedge clk);
        base = logTx.size();
        applyStimulus(1'b1, 8'h55, 1'b0, 8'h00);
        @(negedge clk);
        checkOutput("tmo tx_en", 32'(bus.tx_en), 1);
        n = 0;
        @(negedge clk);
        while (bus.sched_busy && !bus.tmo_err && n < 100) begin
            n++;
            @(negedge clk);
        end
        checkOutput("tmo WAIT_HI cycles", 32'(n), 32'(BUSY_TMO));
        checkOutput("tmo err set", 32'(bus.tmo_err), 1);
        checkOutput("tmo back to idle", 32'(bus.sched_busy), 0);
        checkOutput("tmo byte sent", logAt(base), 32'h55);
        bus.tmo_clr = 1'b1;
        @(negedge clk);
        bus.tmo_clr = 1'b0;
        checkOutput("tmo cleared", 32'(bus.tmo_err), 0);

        // Clear held high through the whole timeout: the set must still be seen once.
        bus.tmo_clr = 1'b1;
        applyStimulus(1'b1, 8'h56, 1'b0, 8'h00);
        @(negedge clk);
        repeat (BUSY_TMO + 1) @(negedge clk);
        checkOutput("tmo set beats clear", 32'(bus.tmo_err), 1);
        checkOutput("tmo second idle", 32'(bus.sched_busy), 0);
        @(negedge clk);
        checkOutput("tmo clear after set", 32'(bus.tmo_err), 0);
        bus.tmo_clr = 1'b0;
        xmitMode = 0;
        repeat (2) @(negedge clk);

        $display("[TB] push and pop in the same cycle");
        xmitMode = 1;
        repeat (2) @(negedge clk);
        base = logTx.size();
        applyStimulus(1'b1, 8'h70, 1'b0, 8'h00);
        applyStimulus(1'b1, 8'h71, 1'b0, 8'h00);
        applyStimulus(1'b1, 8'h72, 1'b0, 8'h00);
        checkOutput("simul cnt0 before", 32'(bus.cnt0), 2);
        xmitMode = 0;
        n = 0;
        while (bus.sched_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("simul reached idle", 32'(n < 50), 1);
        applyStimulus(1'b1, 8'h77, 1'b0, 8'h00);
        checkOutput("simul cnt0 held", 32'(bus.cnt0), 2);
        checkOutput("simul tx_en", 32'(bus.tx_en), 1);
        checkOutput("simul tx_data", 32'(bus.tx_data), 32'h71);
        waitIdle(200);
        checkOutput("simul count", 32'(logTx.size() - base), 4);
        checkOutput("simul byte2", logAt(base + 2), 32'h72);
        checkOutput("simul byte3", logAt(base + 3), 32'h77);

        $display("[TB] reset mid-frame");
        applyStimulus(1'b1, 8'h81, 1'b0, 8'h00);
        applyStimulus(1'b1, 8'h82, 1'b0, 8'h00);
        applyStimulus(1'b1, 8'h83, 1'b0, 8'h00);
        applyStimulus(1'b1, 8'h84, 1'b0, 8'h00);
        repeat (2) @(negedge clk);
        checkOutput("midreset busy before", 32'(bus.sched_busy), 1);
        checkOutput("midreset cnt0 before", 32'(bus.cnt0), 3);
        checkOutput("midreset tx_data before", 32'(bus.tx_data), 32'h81);
        #1 rstn = 1'b0;
        #1;
        checkOutput("midreset tx_en", 32'(bus.tx_en), 0);
        checkOutput("midreset tx_data", 32'(bus.tx_data), 0);
        checkOutput("midreset cnt0", 32'(bus.cnt0), 0);
        checkOutput("midreset cnt1", 32'(bus.cnt1), 0);
        checkOutput("midreset req0_ready", 32'(bus.req0_ready), 1);
        checkOutput("midreset sched_busy", 32'(bus.sched_busy), 0);
        checkOutput("midreset tmo_err", 32'(bus.tmo_err), 0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        base = logTx.size();
        repeat (30) @(negedge clk);
        checkOutput("midreset no tx after release", 32'(logTx.size() - base), 0);
        checkOutput("midreset still idle", 32'(bus.sched_busy), 0);

        $display("[TB] push on first edge after reset");
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        base = logTx.size();
        applyStimulus(1'b1, 8'h99, 1'b0, 8'h00);
        checkOutput("first-edge push cnt0", 32'(bus.cnt0), 1);
        waitIdle(100);
        checkOutput("first-edge byte sent", logAt(base), 32'h99);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
